// File: rtl/ras_pkg.sv
// Shared types and constants for the return address stack controller.
package ras_pkg;
    localparam int          XLEN_DEFAULT     = 32;
    localparam logic [31:0] RAS_RESET_TARGET = 32'hFFFF_FFFF;

    // Link registers that mark a JAL/JALR as call or return.
    localparam logic [4:0]  LINK_REG_X1      = 5'd1;
    localparam logic [4:0]  LINK_REG_X5      = 5'd5;

    typedef enum logic {IDLE, RECOVER} ras_state_t;

    function automatic logic is_link_reg(input logic [4:0] r);
        return (r == LINK_REG_X1) || (r == LINK_REG_X5);
    endfunction
endpackage

// File: rtl/ras_ptr.sv
// Next-state for a RAS top-of-stack pointer and saturating occupancy count.
module ras_ptr #(
    parameter int DEPTH = 16,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic [PTR_W-1:0] i_tos,
    input  logic [PTR_W:0]   i_cnt,
    input  logic             i_push,
    input  logic             i_pop,
    output logic [PTR_W-1:0] o_tos,
    output logic [PTR_W:0]   o_cnt
);
    localparam logic [PTR_W:0] CNT_MAX = (PTR_W+1)'(DEPTH);

    logic w_nonempty;
    assign w_nonempty = (i_cnt != '0);

    always_comb begin
        o_tos = i_tos;
        o_cnt = i_cnt;
        if (i_push && i_pop && w_nonempty) begin
            // Top entry is replaced in place; pointer and count hold.
        end else if (i_push) begin
            o_tos = i_tos + 1'b1;
            if (i_cnt != CNT_MAX)
                o_cnt = i_cnt + 1'b1;
        end else if (i_pop && w_nonempty) begin
            o_tos = i_tos - 1'b1;
            o_cnt = i_cnt - 1'b1;
        end
    end
endmodule

// File: rtl/ras_ctrl.sv
// Return address stack controller: speculative push/pop from fetch, committed
// shadow pointer from retire, restore-on-flush through a one-cycle RECOVER state.
module ras_ctrl
    import ras_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int XLEN  = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fetch_call,
    input  logic            fetch_ret,
    input  logic [XLEN-1:0] fetch_pc,
    input  logic            commit_call,
    input  logic            commit_ret,
    input  logic            flush,
    output logic            pred_valid,
    output logic [XLEN-1:0] pred_target,
    output logic            busy,
    output logic            ras_empty,
    output logic            ras_full
);
    localparam logic [PTR_W:0] CNT_MAX = (PTR_W+1)'(DEPTH);

    logic [XLEN-1:0]  r_mem [DEPTH];
    logic [PTR_W-1:0] r_spec_tos, r_com_tos;
    logic [PTR_W:0]   r_spec_cnt, r_com_cnt;
    logic             r_pred_valid;
    logic [XLEN-1:0]  r_pred_target;
    ras_state_t       r_state, w_state_nxt;

    logic             w_fetch_en, w_push, w_pop, w_hit;
    logic [PTR_W-1:0] w_top_idx, w_wr_idx;
    logic [PTR_W-1:0] w_spec_tos_nxt, w_com_tos_nxt;
    logic [PTR_W:0]   w_spec_cnt_nxt, w_com_cnt_nxt;

    // Fetch is ignored in the flush cycle and throughout RECOVER.
    assign w_fetch_en = (r_state == IDLE) && !flush;
    assign w_push     = fetch_call && w_fetch_en;
    assign w_pop      = fetch_ret  && w_fetch_en;
    assign w_hit      = w_pop && (r_spec_cnt != '0);
    assign w_top_idx  = r_spec_tos - 1'b1;
    assign w_wr_idx   = w_hit ? w_top_idx : r_spec_tos;

    ras_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_spec_ptr (
        .i_tos(r_spec_tos), .i_cnt(r_spec_cnt), .i_push(w_push), .i_pop(w_pop),
        .o_tos(w_spec_tos_nxt), .o_cnt(w_spec_cnt_nxt)
    );

    ras_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_com_ptr (
        .i_tos(r_com_tos), .i_cnt(r_com_cnt), .i_push(commit_call), .i_pop(commit_ret),
        .o_tos(w_com_tos_nxt), .o_cnt(w_com_cnt_nxt)
    );

    always_comb begin
        w_state_nxt = r_state;
        if (flush)
            w_state_nxt = RECOVER;
        else if (r_state == RECOVER)
            w_state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_spec_tos    <= '0;
            r_spec_cnt    <= '0;
            r_com_tos     <= '0;
            r_com_cnt     <= '0;
            r_pred_valid  <= 1'b0;
            r_pred_target <= XLEN'(RAS_RESET_TARGET);
        end else begin
            r_state      <= w_state_nxt;
            r_com_tos    <= w_com_tos_nxt;
            r_com_cnt    <= w_com_cnt_nxt;
            r_pred_valid <= w_hit;
            if (w_hit)
                r_pred_target <= r_mem[w_top_idx];
            // Restore from the committed state including this cycle's retire.
            if (flush) begin
                r_spec_tos <= w_com_tos_nxt;
                r_spec_cnt <= w_com_cnt_nxt;
            end else begin
                r_spec_tos <= w_spec_tos_nxt;
                r_spec_cnt <= w_spec_cnt_nxt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && w_push)
            r_mem[w_wr_idx] <= fetch_pc + XLEN'(4);
    end

    assign pred_valid  = r_pred_valid;
    assign pred_target = r_pred_target;
    assign busy        = (r_state == RECOVER);
    assign ras_empty   = (r_spec_cnt == '0);
    assign ras_full    = (r_spec_cnt == CNT_MAX);
endmodule

// File: tb/tb_ras_ctrl.sv
// Directed self-checking bench for ras_ctrl.
module tb_ras_ctrl;
    localparam int DEPTH = 16;
    localparam int XLEN  = 32;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            fetch_call = 1'b0, fetch_ret = 1'b0;
    logic [XLEN-1:0] fetch_pc = '0;
    logic            commit_call = 1'b0, commit_ret = 1'b0, flush = 1'b0;
    logic            pred_valid, busy, ras_empty, ras_full;
    logic [XLEN-1:0] pred_target;

    int n_cmp = 0;
    int n_err = 0;

    ras_ctrl #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .reset(reset),
        .fetch_call(fetch_call), .fetch_ret(fetch_ret), .fetch_pc(fetch_pc),
        .commit_call(commit_call), .commit_ret(commit_ret), .flush(flush),
        .pred_valid(pred_valid), .pred_target(pred_target), .busy(busy),
        .ras_empty(ras_empty), .ras_full(ras_full)
    );

    always #5 clk = ~clk;

    // Apply the current inputs for one clock, then clear them; sample at +1.
    task automatic step();
        @(posedge clk);
        #1;
        fetch_call = 0; fetch_ret = 0; commit_call = 0; commit_ret = 0; flush = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        step(); step();
        reset = 0;
    endtask

    task automatic push(input logic [XLEN-1:0] pc);
        fetch_call = 1; fetch_pc = pc; step();
    endtask

    task automatic pop();
        fetch_ret = 1; step();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (pred_valid !== 1'b0) begin n_err++; $display("FAIL reset_pred_valid got %b want 0", pred_valid); end
        n_cmp++; if (pred_target !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL reset_pred_target got %h want ffffffff", pred_target); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (ras_empty !== 1'b1 || ras_full !== 1'b0) begin n_err++; $display("FAIL reset_flags got empty=%b full=%b want 1/0", ras_empty, ras_full); end
    endtask

    task automatic test_push_pop();
        logic [XLEN-1:0] exp [3];
        exp[0] = 32'h304; exp[1] = 32'h204; exp[2] = 32'h104;
        do_reset();
        push(32'h100); push(32'h200); push(32'h300);
        for (int i = 0; i < 3; i++) begin
            pop();
            n_cmp++;
            if (pred_valid !== 1'b1 || pred_target !== exp[i]) begin
                n_err++; $display("FAIL push_pop_%0d got v=%b t=%h want v=1 t=%h", i, pred_valid, pred_target, exp[i]);
            end
        end
        n_cmp++; if (ras_empty !== 1'b1) begin n_err++; $display("FAIL push_pop_empty got %b want 1", ras_empty); end
        step();
        n_cmp++; if (pred_valid !== 1'b0) begin n_err++; $display("FAIL pred_pulse got %b want 0", pred_valid); end
    endtask

    task automatic test_underflow();
        do_reset();
        pop();
        n_cmp++;
        if (pred_valid !== 1'b0 || pred_target !== 32'hFFFF_FFFF || ras_empty !== 1'b1) begin
            n_err++; $display("FAIL underflow got v=%b t=%h e=%b want v=0 t=ffffffff e=1", pred_valid, pred_target, ras_empty);
        end
        push(32'h40); pop();
        n_cmp++;
        if (pred_valid !== 1'b1 || pred_target !== 32'h44) begin
            n_err++; $display("FAIL after_underflow got v=%b t=%h want v=1 t=00000044", pred_valid, pred_target);
        end
    endtask

    task automatic test_overflow();
        logic [XLEN-1:0] exp;
        do_reset();
        for (int i = 0; i < DEPTH + 2; i++) begin
            push(32'h1000 + 32'(16 * i));
            if (i == DEPTH - 2) begin
                n_cmp++; if (ras_full !== 1'b0) begin n_err++; $display("FAIL full_early got %b want 0", ras_full); end
            end
            if (i == DEPTH - 1) begin
                n_cmp++; if (ras_full !== 1'b1) begin n_err++; $display("FAIL full_at_depth got %b want 1", ras_full); end
            end
        end
        for (int i = DEPTH + 1; i >= 2; i--) begin
            exp = 32'h1000 + 32'(16 * i) + 32'd4;
            pop();
            n_cmp++;
            if (pred_valid !== 1'b1 || pred_target !== exp) begin
                n_err++; $display("FAIL overflow_pop_%0d got v=%b t=%h want v=1 t=%h", i, pred_valid, pred_target, exp);
            end
        end
        pop();
        n_cmp++; if (pred_valid !== 1'b0 || ras_empty !== 1'b1) begin n_err++; $display("FAIL overflow_extra got v=%b e=%b want v=0 e=1", pred_valid, ras_empty); end
    endtask

    task automatic test_call_ret();
        do_reset();
        push(32'h500);
        fetch_call = 1; fetch_ret = 1; fetch_pc = 32'h600; step();
        n_cmp++;
        if (pred_valid !== 1'b1 || pred_target !== 32'h504) begin
            n_err++; $display("FAIL call_ret_pred got v=%b t=%h want v=1 t=00000504", pred_valid, pred_target);
        end
        n_cmp++; if (dut.r_spec_cnt !== 5'd1) begin n_err++; $display("FAIL call_ret_cnt got %0d want 1", dut.r_spec_cnt); end
        pop();
        n_cmp++;
        if (pred_valid !== 1'b1 || pred_target !== 32'h604) begin
            n_err++; $display("FAIL call_ret_replaced got v=%b t=%h want v=1 t=00000604", pred_valid, pred_target);
        end
    endtask

    task automatic test_flush();
        do_reset();
        commit_call = 1; step();
        commit_call = 1; step();
        for (int i = 0; i < 4; i++) push(32'h2000 + 32'(16 * i));
        pop();
        n_cmp++; if (dut.r_spec_cnt !== 5'd3) begin n_err++; $display("FAIL pre_flush_cnt got %0d want 3", dut.r_spec_cnt); end
        flush = 1; step();
        n_cmp++; if (busy !== 1'b1 || pred_valid !== 1'b0) begin n_err++; $display("FAIL flush_busy got busy=%b v=%b want 1/0", busy, pred_valid); end
        fetch_call = 1; fetch_pc = 32'h3000; step();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL busy_one_cycle got %b want 0", busy); end
        n_cmp++; if (dut.r_spec_cnt !== 5'd2) begin n_err++; $display("FAIL flush_restore_cnt got %0d want 2", dut.r_spec_cnt); end
        step();
        n_cmp++; if (busy !== 1'b0 || dut.r_spec_cnt !== 5'd2) begin n_err++; $display("FAIL post_recover got busy=%b cnt=%0d want 0/2", busy, dut.r_spec_cnt); end
    endtask

    task automatic test_flush_commit_and_reset();
        do_reset();
        for (int i = 0; i < 3; i++) begin commit_call = 1; step(); end
        flush = 1; commit_ret = 1; step();
        n_cmp++;
        if (dut.r_spec_cnt !== 5'd2 || dut.r_com_cnt !== 5'd2) begin
            n_err++; $display("FAIL flush_commit_ret got spec=%0d com=%0d want 2/2", dut.r_spec_cnt, dut.r_com_cnt);
        end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL flush_commit_busy got %b want 1", busy); end
        reset = 1; step(); reset = 0;
        n_cmp++;
        if (busy !== 1'b0 || dut.r_spec_cnt !== 5'd0 || dut.r_com_cnt !== 5'd0) begin
            n_err++; $display("FAIL reset_in_recover got busy=%b spec=%0d com=%0d want 0/0/0", busy, dut.r_spec_cnt, dut.r_com_cnt);
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_push_pop();
        test_underflow();
        test_overflow();
        test_call_ret();
        test_flush();
        test_flush_commit_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/ras_ctrl.md
Name: ras_ctrl

Overview:
Clocked controller for the return address stack used by the fetch stage. It sequences speculative push/pop from fetch-stage call/return predecode and keeps a parallel committed pointer/count updated at retire. On a pipeline flush it restores the speculative state from the committed state. Sits between fetch predecode, the next-PC mux and the retire stage.

Parameters:
DEPTH, 16, number of return-address entries; power of two, at least 2
PTR_W, $clog2(DEPTH), width of the top-of-stack pointer
XLEN, 32, address width

Ports:
clk  in  1  clock
reset  in  1  reset; synchronous, active-high
fetch_call  in  1  predecoded call (JAL/JALR with rd=x1/x5) in fetch
fetch_ret  in  1  predecoded return (JALR rs1=x1/x5, rd=x0) in fetch
fetch_pc  in  XLEN  PC of the fetch instruction
commit_call  in  1  call retired
commit_ret  in  1  return retired
flush  in  1  mispredict/exception flush from execute/retire
pred_valid  out  1  pred_target holds a valid return prediction
pred_target  out  XLEN  predicted return address
busy  out  1  recovery in progress; fetch must hold and must not assert fetch_call/fetch_ret
ras_empty  out  1  speculative count == 0
ras_full  out  1  speculative count == DEPTH

Behaviour:
- State: mem[0..DEPTH-1] (not reset). spec_tos/com_tos are PTR_W bits, modulo DEPTH. spec_cnt/com_cnt are PTR_W+1 bits, saturating at DEPTH.
- Reset: spec_tos=com_tos=0, spec_cnt=com_cnt=0, pred_valid=0, pred_target=32'hFFFFFFFF, busy=0, FSM=IDLE. Reset overrides flush and recovery in any state.
- Push (fetch_call only):
  - mem[spec_tos] <= fetch_pc+4, modulo 2^XLEN.
  - spec_tos++.
  - spec_cnt = min(cnt+1, DEPTH). At full, the oldest entry is overwritten silently and the count stays DEPTH.
- Pop (fetch_ret only):
  - If cnt>0: pred_target <= mem[spec_tos-1], pred_valid <= 1, spec_tos--, cnt--.
  - If cnt==0 (underflow): pred_valid <= 0, pred_target unchanged, pointer and count unchanged.
- Pop+push in the same cycle (fetch_call and fetch_ret):
  - If cnt>0: prediction = mem[tos-1], then mem[tos-1] <= fetch_pc+4; tos and cnt unchanged.
  - If cnt==0: pred_valid <= 0 and a normal push is performed.
- Latency: prediction is registered, valid the cycle after fetch_ret. pred_valid is a one-cycle pulse; it is 0 in any cycle without a pop.
- Commit path: com_tos/com_cnt follow the same pointer/count rules on commit_call/commit_ret, with no memory access.
- FSM states:
  - IDLE: normal operation.
  - On flush: spec_tos <= com_tos' and spec_cnt <= com_cnt', where ' means after applying this cycle's commit update. Fetch inputs are ignored that cycle, pred_valid <= 0, go to RECOVER.
  - RECOVER: busy=1 for exactly one cycle. Fetch inputs are ignored, commit inputs are still applied, then return to IDLE.
  - A flush while in RECOVER restarts the restore and stays in RECOVER for one more cycle.
- Entries overwritten speculatively before a flush are not repaired. This is an accepted accuracy loss: the prediction may be wrong, but pointers are always consistent.
- ras_empty/ras_full are combinational from spec_cnt.

Decomposition:
- Package ras_pkg holds:
  - XLEN_DEFAULT=32
  - RAS_RESET_TARGET=32'hFFFFFFFF
  - the enum ras_state_t {IDLE, RECOVER}
  - the link-register predicate constants (x1, x5)
- Sub-module ras_ptr: pointer/count next-state unit (inputs push/pop, outputs next tos/cnt with wrap and saturation). It is instantiated twice, for the speculative and committed paths.

Test Plan:
- Reset, then 3 pushes (fetch_pc=0x100, 0x200, 0x300), then 3 pops:
  - pred_target = 0x304, 0x204, 0x104, each with pred_valid=1 one cycle after its pop.
  - ras_empty=1 at the end.
- Pop when empty: pred_valid=0 and pred_target stays 0xFFFFFFFF; then a push of 0x40 and a pop -> 0x44.
- Overflow: DEPTH+2 pushes (pc=0x1000+16*i), then DEPTH pops:
  - pops return the newest DEPTH addresses in reverse order.
  - the (DEPTH+1)th pop gives pred_valid=0.
  - ras_full=1 after the DEPTH-th push.
- Simultaneous call+ret with the stack holding 0x504: pred_target=0x504, and a following pop returns fetch_pc+4 of the call+ret instruction; count unchanged.
- Flush recovery:
  - Sequence: commit 2 calls, 4 speculative pushes, 1 speculative pop, then flush.
  - Required: spec_cnt=2 two cycles later, busy high for exactly 1 cycle, and fetch_call during busy is ignored.
- Flush in the same cycle as commit_ret with com_cnt=3 -> spec_cnt=2. Also: reset asserted during RECOVER -> busy=0 and all counts 0 the next cycle.
